// File: rtl/mdu_iter.sv
// mdu_iter: iterative RV32M multiply/divide unit for the execute stage.
// Shift-add multiply or restoring divide, one bit per cycle, XLEN cycles.
//
// Ports:
//   clk_i, rst_i             clock, synchronous active-high reset
//   valid_i / ready_o        operation handshake (ready_o only in IDLE)
//   op_i                     RV32M funct3
//   operand_a_i/operand_b_i  rs1 / rs2 values
//   rd_addr_i, rd_wr_en_i    destination, forwarded to the result
//   kill_i                   flush: abort and discard the current op
//   valid_o / ready_i        result handshake (valid_o only in DONE)
//   reg_we_o, wr_addr_o      register-file write enable / address
//   rd_wdata_o               result
module mdu_iter #(
   parameter int XLEN = 32,
   parameter int AW   = 5
) (
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic            valid_i,
   output logic            ready_o,
   input  logic [2:0]      op_i,
   input  logic [XLEN-1:0] operand_a_i,
   input  logic [XLEN-1:0] operand_b_i,
   input  logic [AW-1:0]   rd_addr_i,
   input  logic            rd_wr_en_i,
   input  logic            kill_i,
   output logic            valid_o,
   input  logic            ready_i,
   output logic            reg_we_o,
   output logic [AW-1:0]   wr_addr_o,
   output logic [XLEN-1:0] rd_wdata_o
);

   localparam int CW = $clog2(XLEN);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_CALC = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   localparam logic [CW-1:0] CNT_LAST = CW'(XLEN - 1);

   localparam logic [XLEN-1:0] MIN_NEG =
      {1'b1, {(XLEN-1){1'b0}}};

   logic [1:0]        state;
   logic [CW-1:0]     cnt;
   logic [2:0]        op_q;
   logic              neg_q;
   logic              we_q;

   // mul: acc = product, md = shifted multiplicand,
   //      mb = multiplier shifted right.
   // div: acc = {remainder, dividend/quotient},
   //      md[XLEN-1:0] = divisor.
   logic [2*XLEN-1:0] acc;
   logic [2*XLEN-1:0] md;
   logic [XLEN-1:0]   mb;

   // ---------------- accept-side decode ----------------
   logic            signed_a;
   logic            signed_b;
   logic            sign_a;
   logic            sign_b;
   logic            neg_in;
   logic [XLEN-1:0] mag_a;
   logic [XLEN-1:0] mag_b;
   logic            b_zero;
   logic            ovf;
   logic            special;
   logic [XLEN-1:0] spec_res;

   assign signed_a = (op_i == 3'd1) | (op_i == 3'd2)
                   | (op_i == 3'd4) | (op_i == 3'd6);
   assign signed_b = (op_i == 3'd1) | (op_i == 3'd4)
                   | (op_i == 3'd6);

   assign sign_a = signed_a & operand_a_i[XLEN-1];
   assign sign_b = signed_b & operand_b_i[XLEN-1];

   // REM takes the dividend's sign; everything else
   // takes the product/quotient sign.
   assign neg_in = (op_i[2] & op_i[1]) ? sign_a
                                       : (sign_a ^ sign_b);

   assign mag_a = sign_a ? -operand_a_i : operand_a_i;
   assign mag_b = sign_b ? -operand_b_i : operand_b_i;

   assign b_zero = (operand_b_i == '0);
   assign ovf    = op_i[2] & ~op_i[0]
                 & (operand_a_i == MIN_NEG)
                 & (&operand_b_i);

   assign special = op_i[2] & (b_zero | ovf);

   // op_i[1] selects remainder vs quotient among divides.
   assign spec_res = b_zero ? (op_i[1] ? operand_a_i : '1)
                            : (op_i[1] ? '0 : operand_a_i);

   // ---------------- iteration datapath ----------------
   logic [2*XLEN-1:0] mul_acc_n;
   logic [XLEN:0]     diff;
   logic [2*XLEN-1:0] div_acc_n;
   logic [2*XLEN-1:0] acc_n;

   assign mul_acc_n = acc + (mb[0] ? md : '0);

   // Trial subtraction of the divisor from the
   // shifted partial remainder; the top bit is the borrow.
   assign diff = acc[2*XLEN-1:XLEN-1]
               - {1'b0, md[XLEN-1:0]};

   assign div_acc_n = diff[XLEN]
      ? {acc[2*XLEN-2:0], 1'b0}
      : {diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};

   assign acc_n = op_q[2] ? div_acc_n : mul_acc_n;

   // ---------------- final result ----------------
   logic [2*XLEN-1:0] prod;
   logic [XLEN-1:0]   mul_res;
   logic [XLEN-1:0]   div_sel;
   logic [XLEN-1:0]   div_res;
   logic [XLEN-1:0]   calc_res;

   assign prod    = neg_q ? -acc_n : acc_n;
   assign mul_res = (op_q[1:0] == 2'd0) ? prod[XLEN-1:0]
                                        : prod[2*XLEN-1:XLEN];

   assign div_sel = op_q[1] ? acc_n[2*XLEN-1:XLEN]
                            : acc_n[XLEN-1:0];
   assign div_res = neg_q ? -div_sel : div_sel;

   assign calc_res = op_q[2] ? div_res : mul_res;

   // ---------------- control ----------------
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state      <= S_IDLE;
         cnt        <= '0;
         op_q       <= '0;
         neg_q      <= 1'b0;
         we_q       <= 1'b0;
         acc        <= '0;
         md         <= '0;
         mb         <= '0;
         wr_addr_o  <= '0;
         rd_wdata_o <= '0;
      end else if (kill_i) begin
         state <= S_IDLE;
         cnt   <= '0;
      end else begin
         unique case (1'b1)
            (state == S_IDLE): begin
               if (valid_i) begin
                  op_q      <= op_i;
                  neg_q     <= neg_in;
                  we_q      <= rd_wr_en_i;
                  wr_addr_o <= rd_addr_i;
                  acc <= op_i[2]
                     ? {{XLEN{1'b0}}, mag_a}
                     : '0;
                  md <= {{XLEN{1'b0}},
                         (op_i[2] ? mag_b : mag_a)};
                  mb  <= mag_b;
                  cnt <= '0;
                  if (special) begin
                     rd_wdata_o <= spec_res;
                     state      <= S_DONE;
                  end else begin
                     state <= S_CALC;
                  end
               end
            end
            (state == S_CALC): begin
               acc <= acc_n;
               if (!op_q[2]) begin
                  md <= md << 1;
                  mb <= mb >> 1;
               end
               if (cnt == CNT_LAST) begin
                  rd_wdata_o <= calc_res;
                  cnt        <= '0;
                  state      <= S_DONE;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            (state == S_DONE): begin
               if (ready_i) state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   assign ready_o  = (state == S_IDLE);
   assign valid_o  = (state == S_DONE);
   assign reg_we_o = valid_o & we_q;

endmodule

// File: tb/tb_mdu_iter.sv
// tb_mdu_iter: scoreboard bench for mdu_iter.
// Directed RV32M cases, kill/reset scenarios, random ops.
module tb_mdu_iter;

   localparam int XLEN = 32;
   localparam int AW   = 5;

   logic            clk = 1'b0;
   logic            rst_i;
   logic            valid_i;
   logic            ready_o;
   logic [2:0]      op_i;
   logic [XLEN-1:0] operand_a_i;
   logic [XLEN-1:0] operand_b_i;
   logic [AW-1:0]   rd_addr_i;
   logic            rd_wr_en_i;
   logic            kill_i;
   logic            valid_o;
   logic            ready_i;
   logic            reg_we_o;
   logic [AW-1:0]   wr_addr_o;
   logic [XLEN-1:0] rd_wdata_o;

   mdu_iter #(.XLEN(XLEN), .AW(AW)) dut (
      .clk_i      (clk),
      .rst_i      (rst_i),
      .valid_i    (valid_i),
      .ready_o    (ready_o),
      .op_i       (op_i),
      .operand_a_i(operand_a_i),
      .operand_b_i(operand_b_i),
      .rd_addr_i  (rd_addr_i),
      .rd_wr_en_i (rd_wr_en_i),
      .kill_i     (kill_i),
      .valid_o    (valid_o),
      .ready_i    (ready_i),
      .reg_we_o   (reg_we_o),
      .wr_addr_o  (wr_addr_o),
      .rd_wdata_o (rd_wdata_o)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [31:0] data;
      logic [4:0]  addr;
      logic        we;
      int          acc;
      int          lat;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   passed = 0;
   bit   rdy_rand = 1'b0;

   task automatic chk(input string name,
                      input logic [63:0] act,
                      input logic [63:0] req);
      checks++;
      if (act === req) passed++;
      else $display("FAIL %s: got %0h want %0h",
                    name, act, req);
   endtask

   // Reference model: plain 64-bit arithmetic.
   function automatic logic [31:0] ref_model(
      input logic [2:0] o,
      input logic [31:0] x,
      input logic [31:0] y);
      longint      sx;
      longint      sy;
      longint      uy;
      longint      p;
      logic [63:0] up;
      int          ix;
      int          iy;
      sx = longint'($signed(x));
      sy = longint'($signed(y));
      uy = longint'({32'd0, y});
      ix = x;
      iy = y;
      up = {32'd0, x} * {32'd0, y};
      case (o)
         3'd0: return up[31:0];
         3'd1: begin p = sx * sy; return p[63:32]; end
         3'd2: begin p = sx * uy; return p[63:32]; end
         3'd3: return up[63:32];
         3'd4: begin
            if (y == 0) return 32'hFFFF_FFFF;
            if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF)
               return x;
            return ix / iy;
         end
         3'd5: return (y == 0) ? 32'hFFFF_FFFF : x / y;
         3'd6: begin
            if (y == 0) return x;
            if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF)
               return 32'd0;
            return ix % iy;
         end
         default: return (y == 0) ? x : x % y;
      endcase
   endfunction

   function automatic int lat_model(
      input logic [2:0] o,
      input logic [31:0] x,
      input logic [31:0] y);
      if (o >= 3'd4 && y == 0) return 1;
      if ((o == 3'd4 || o == 3'd6) &&
          x == 32'h8000_0000 && y == 32'hFFFF_FFFF)
         return 1;
      return XLEN + 1;
   endfunction

   // Monitor: pop and compare on each result handshake.
   initial begin
      bit seen;
      int rise;
      exp_t e;
      seen = 1'b0;
      rise = 0;
      forever begin
         @(negedge clk);
         if (rst_i) begin
            seen = 1'b0;
         end else begin
            if (valid_o && !seen) begin
               seen = 1'b1;
               rise = cyc;
            end
            if (valid_o && kill_i) begin
               seen = 1'b0;
            end else if (valid_o && ready_i) begin
               if (sb.size() == 0) begin
                  chk("unexpected_result", 64'(rd_wdata_o),
                      64'hDEAD);
               end else begin
                  e = sb.pop_front();
                  chk("rd_wdata", 64'(rd_wdata_o), 64'(e.data));
                  chk("wr_addr", 64'(wr_addr_o), 64'(e.addr));
                  chk("reg_we", 64'(reg_we_o), 64'(e.we));
                  chk("latency", 64'(rise - e.acc),
                      64'(e.lat));
               end
               seen = 1'b0;
            end
         end
      end
   end

   // Random result backpressure when enabled.
   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (rdy_rand) ready_i = 1'($urandom_range(0, 1));
      end
   end

   // Issue one op; called at posedge+1. Returns at posedge+1
   // after the accept edge. acc = cyc seen before that edge.
   task automatic issue(input logic [2:0] o,
                        input logic [31:0] x,
                        input logic [31:0] y,
                        input logic [4:0] r,
                        input logic w,
                        input logic [31:0] e,
                        input bit push,
                        output int acc);
      bit ok;
      int n;
      ok  = 1'b0;
      n   = 0;
      acc = 0;
      op_i        = o;
      operand_a_i = x;
      operand_b_i = y;
      rd_addr_i   = r;
      rd_wr_en_i  = w;
      valid_i     = 1'b1;
      while (!ok && n < 200) begin
         @(negedge clk);
         if (ready_o && !kill_i) begin
            ok  = 1'b1;
            acc = cyc;
         end
         @(posedge clk);
         n++;
      end
      #1;
      valid_i     = 1'b0;
      operand_a_i = $urandom;
      operand_b_i = $urandom;
      op_i        = 3'($urandom);
      rd_addr_i   = 5'($urandom);
      rd_wr_en_i  = 1'($urandom);
      if (!ok) chk("accept_timeout", 64'(ok), 64'd1);
      else if (push)
         sb.push_back('{e, r, w, acc, lat_model(o, x, y)});
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while ((sb.size() != 0 || !ready_o) && n < 500) begin
         @(negedge clk);
         n++;
      end
      if (n >= 500) chk("idle_timeout", 64'(n), 64'd0);
      @(posedge clk);
      #1;
   endtask

   int a_c;

   initial begin
      logic [31:0] specials [5];
      logic [31:0] x;
      logic [31:0] y;
      logic [2:0]  o;
      int          n;
      specials[0] = 32'h0;
      specials[1] = 32'h1;
      specials[2] = 32'hFFFF_FFFF;
      specials[3] = 32'h8000_0000;
      specials[4] = 32'h7FFF_FFFF;

      rst_i       = 1'b1;
      valid_i     = 1'b0;
      kill_i      = 1'b0;
      ready_i     = 1'b1;
      op_i        = '0;
      operand_a_i = '0;
      operand_b_i = '0;
      rd_addr_i   = '0;
      rd_wr_en_i  = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      rst_i = 1'b0;
      @(negedge clk);
      chk("reset_valid", 64'(valid_o), 64'd0);
      chk("reset_ready", 64'(ready_o), 64'd1);
      chk("reset_we", 64'(reg_we_o), 64'd0);
      chk("reset_addr", 64'(wr_addr_o), 64'd0);
      chk("reset_data", 64'(rd_wdata_o), 64'd0);
      @(posedge clk);
      #1;

      // Directed cases with known results.
      issue(3'd0, 32'd7, 32'd6, 5'd3, 1'b1, 32'd42, 1, a_c);
      issue(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd4, 1'b1,
            32'h0, 1, a_c);
      issue(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd5, 1'b1,
            32'hFFFF_FFFE, 1, a_c);
      issue(3'd2, 32'hFFFF_FFFF, 32'd2, 5'd6, 1'b0,
            32'hFFFF_FFFF, 1, a_c);
      issue(3'd4, -32'sd20, 32'd3, 5'd7, 1'b1,
            32'hFFFF_FFFA, 1, a_c);
      issue(3'd6, -32'sd20, 32'd3, 5'd8, 1'b1,
            32'hFFFF_FFFE, 1, a_c);
      issue(3'd5, 32'd20, 32'd3, 5'd9, 1'b1, 32'd6, 1, a_c);
      issue(3'd4, 32'd5, 32'd0, 5'd10, 1'b1,
            32'hFFFF_FFFF, 1, a_c);
      issue(3'd7, 32'd5, 32'd0, 5'd11, 1'b1, 32'd5, 1, a_c);
      issue(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd12, 1'b1,
            32'h8000_0000, 1, a_c);
      issue(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd13, 1'b1,
            32'h0, 1, a_c);
      wait_idle();

      // Backpressure in DONE, then kill.
      ready_i = 1'b0;
      issue(3'd5, 32'd100, 32'd7, 5'd9, 1'b1, 32'd14, 0, a_c);
      n = 0;
      while (!valid_o && n < 100) begin
         @(negedge clk);
         n++;
      end
      chk("bp_valid_seen", 64'(valid_o), 64'd1);
      repeat (5) begin
         @(negedge clk);
         chk("bp_data", 64'(rd_wdata_o), 64'd14);
         chk("bp_addr", 64'(wr_addr_o), 64'd9);
         chk("bp_we", 64'(reg_we_o), 64'd1);
         chk("bp_ready", 64'(ready_o), 64'd0);
      end
      @(posedge clk);
      #1;
      kill_i = 1'b1;
      @(posedge clk);
      #1;
      kill_i = 1'b0;
      @(negedge clk);
      chk("kill_done_valid", 64'(valid_o), 64'd0);
      chk("kill_done_we", 64'(reg_we_o), 64'd0);
      chk("kill_done_ready", 64'(ready_o), 64'd1);
      ready_i = 1'b1;
      @(posedge clk);
      #1;

      // Kill at CALC cycle 10, then MUL 3 x 3.
      issue(3'd0, 32'd123, 32'd456, 5'd1, 1'b1, 32'd0, 0, a_c);
      repeat (9) @(posedge clk);
      #1;
      kill_i = 1'b1;
      @(posedge clk);
      #1;
      kill_i = 1'b0;
      @(negedge clk);
      chk("kill_calc_ready", 64'(ready_o), 64'd1);
      chk("kill_calc_valid", 64'(valid_o), 64'd0);
      @(posedge clk);
      #1;
      issue(3'd0, 32'd3, 32'd3, 5'd14, 1'b1, 32'd9, 1, a_c);
      wait_idle();

      // Reset at CALC cycle 20.
      issue(3'd4, 32'd1000, 32'd7, 5'd17, 1'b1, 32'd0, 0, a_c);
      repeat (19) @(posedge clk);
      #1;
      rst_i = 1'b1;
      @(posedge clk);
      #1;
      rst_i = 1'b0;
      @(negedge clk);
      chk("rst_calc_valid", 64'(valid_o), 64'd0);
      chk("rst_calc_ready", 64'(ready_o), 64'd1);
      chk("rst_calc_we", 64'(reg_we_o), 64'd0);
      chk("rst_calc_addr", 64'(wr_addr_o), 64'd0);
      chk("rst_calc_data", 64'(rd_wdata_o), 64'd0);
      @(posedge clk);
      #1;

      // Random operations against the reference model.
      rdy_rand = 1'b1;
      for (int i = 0; i < 40; i++) begin
         o = 3'($urandom);
         case ($urandom_range(0, 2))
            0: begin x = $urandom; y = $urandom; end
            1: begin
               x = $urandom_range(0, 300);
               y = $urandom_range(0, 20);
            end
            default: begin
               x = specials[$urandom_range(0, 4)];
               y = specials[$urandom_range(0, 4)];
            end
         endcase
         issue(o, x, y, 5'($urandom), 1'($urandom),
               ref_model(o, x, y), 1, a_c);
      end
      wait_idle();
      rdy_rand = 1'b0;
      ready_i  = 1'b1;

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule

// File: doc/mdu_iter.md
# mdu_iter

Parametrised iterative multiply/divide unit for the milano core, executing the RV32M operations beside the single-cycle integer ALU in the execute stage. It accepts one operation per valid/ready handshake and runs a shift-add multiplier or restoring divider over XLEN cycles. It returns the result with the destination register address and write enable forwarded, so it can drive the register-file write port the same way the ALU does. Division-by-zero and signed-overflow cases complete early. A kill input aborts an in-flight operation on a pipeline flush.

## Interface
Parameters:
- XLEN, 32, operand/result width; any value ≥ 4.
- AW, 5, register address width.

Ports:
- clk_i  in  1  clock; all state updates on rising edge.
- rst_i  in  1  reset; synchronous, active-high.
- valid_i  in  1  operation request.
- ready_o  out  1  unit can accept; high only in IDLE.
- op_i  in  3  operation code: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU (RISC-V funct3).
- operand_a_i  in  XLEN  rs1 value, multiplicand or dividend.
- operand_b_i  in  XLEN  rs2 value, multiplier or divisor.
- rd_addr_i  in  AW  destination register.
- rd_wr_en_i  in  1  destination write enable.
- kill_i  in  1  abort the current operation and discard its result.
- valid_o  out  1  result available; high only in DONE.
- ready_i  in  1  consumer takes the result.
- reg_we_o  out  1  captured rd_wr_en_i, qualified by valid_o.
- wr_addr_o  out  AW  captured rd_addr_i.
- rd_wdata_o  out  XLEN  result.

## Operation
- **States:** IDLE, CALC, DONE.
- **IDLE:**
  - ready_o = 1.
  - When valid_i & ~kill_i: latch op, operands, rd_addr and rd_wr_en; go to CALC (or directly to DONE for a special case).
- **Sign handling at accept:**
  - Signed operands are a (MULH, MULHSU, DIV, REM) and b (MULH, DIV, REM).
  - Each operand is converted to its magnitude.
  - neg_res = sign(a) ^ sign(b) for MUL/MULH/MULHSU/DIV.
  - neg_res = sign(a) for REM.
  - MUL uses the unsigned datapath; its low XLEN bits are sign-independent.
- **Multiply:**
  - 2·XLEN accumulator; each CALC cycle adds the shifted multiplicand when the current multiplier bit is set.
  - Iteration counter runs 0..XLEN-1.
  - At the end, negate the 2·XLEN product (two's complement) when neg_res.
  - MUL returns the low XLEN bits; MULH/MULHSU/MULHU return the high XLEN bits.
- **Divide:**
  - Restoring, one quotient bit per CALC cycle, XLEN cycles.
  - The quotient is negated when neg_res (DIV); the remainder is negated when neg_res (REM).
- **Special cases** (decided at accept; CALC is skipped):
  - b == 0:
    - DIV/DIVU → all ones.
    - REM/REMU → a.
  - Signed overflow (DIV/REM with a = 1 followed by zeros, b = all ones):
    - DIV → a.
    - REM → 0.
- **CALC:** after the last iteration, write rd_wdata_o and go to DONE.
- **DONE:**
  - valid_o = 1; outputs are held stable until ready_i.
  - valid_o & ready_i → IDLE.
  - No new operation is accepted in the same cycle (ready_o = 0 in DONE).
- **kill_i:**
  - In any state, the next state is IDLE and the result is discarded.
  - valid_o drops the next cycle.
  - kill_i wins over valid_i and ready_i when they occur in the same cycle.
- **rst_i:**
  - Overrides everything, including mid-CALC.
  - Next cycle: IDLE, counter 0.
  - Output values after reset:
    - valid_o = 0, reg_we_o = 0, wr_addr_o = 0, rd_wdata_o = 0.
    - ready_o = 1.

## Timing
- All outputs are registered or decoded from the state register; no combinational path from the inputs to valid_o or ready_o.
- Normal latency:
  - Accept edge at cycle 0.
  - CALC occupies cycles 1..XLEN.
  - valid_o rises at cycle XLEN+1 (33 for XLEN = 32).
- Special-case latency: valid_o at cycle 1.
- Throughput: at most one operation per XLEN+2 cycles.
- reg_we_o = valid_o & captured rd_wr_en; an idle unit never asserts a write.
- Input operands may change after the accept edge without affecting the result.

## Test plan
- **MUL:** MUL 7 × 6, rd = 3, we = 1 → valid_o at cycle 33; rd_wdata_o = 42; wr_addr_o = 3; reg_we_o = 1.
- **High-half multiplies:**
  - MULH 0xFFFFFFFF × 0xFFFFFFFF → 0x00000000.
  - MULHU of the same operands → 0xFFFFFFFE.
  - MULHSU 0xFFFFFFFF × 2 → 0xFFFFFFFF.
- **Signed divide/remainder:**
  - DIV −20 ÷ 3 → 0xFFFFFFFA (−6).
  - REM −20 ÷ 3 → 0xFFFFFFFE (−2).
  - DIVU 20 ÷ 3 → 6.
- **Special cases:**
  - DIV 5 ÷ 0 → 0xFFFFFFFF at cycle 1.
  - REMU 5 ÷ 0 → 5.
  - DIV 0x80000000 ÷ 0xFFFFFFFF → 0x80000000.
  - REM of the same operands → 0.
- **Backpressure then kill:**
  - Hold ready_i = 0 for 5 cycles in DONE → outputs stable, ready_o = 0.
  - Assert kill_i → IDLE, valid_o = 0 next cycle, no write.
- **Kill and reset mid-operation:**
  - kill_i at CALC cycle 10 → ready_o = 1 next cycle; a new MUL 3 × 3 then returns 9 at its cycle 33.
  - rst_i at CALC cycle 20 → all outputs at their reset values next cycle.
